// File: rtl/reset_monitor.sv
// reset_monitor: per-source reset/event qualifier with sticky cause flags.
//
// Each source runs a small FSM (IDLE -> QUAL -> HELD). A source qualifies once
// src_req has been sampled high for MIN_WIDTH consecutive cycles. Shorter pulses
// are rejected as glitches. A qualification produces:
//   - a one-cycle evt_pulse,
//   - a sticky cause flag,
//   - an evt_cnt increment,
//   - an update of last_src.
// cause, evt_cnt and last_src survive rst. Only configuration initialises them,
// so the cause of a reset can still be read after that reset.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   src_req   in   [N_SRC] raw requests, already synchronous to clk
//   clr       in   one-cycle clear strobe for cause flags
//   clr_mask  in   [N_SRC] which cause flags clr affects
//   power_up  out  high from configuration until rst is first sampled high
//   cause     out  [N_SRC] sticky qualified-event flags
//   evt_pulse out  [N_SRC] one-cycle pulse per qualification
//   evt_cnt   out  [CNT_W] total qualified events
//   last_src  out  index of the most recently qualified source
//
// Build option:
//   RESET_MONITOR_SAT_EN  defined: evt_cnt saturates at all-ones.
//                         undefined: evt_cnt wraps.
module reset_monitor #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned MIN_WIDTH = 3,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_req,
    input  logic             clr,
    input  logic [N_SRC-1:0] clr_mask,
    output logic             power_up,
    output logic [N_SRC-1:0] cause,
    output logic [N_SRC-1:0] evt_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [SRC_W-1:0] last_src
);

    typedef enum logic [1:0] {StIdle, StQual, StHeld} state_e;

    localparam logic [8:0] MinW = 9'(MIN_WIDTH);

    state_e           state_q [N_SRC];
    state_e           state_d [N_SRC];
    logic [7:0]       wcnt_q  [N_SRC];
    logic [7:0]       wcnt_d  [N_SRC];
    logic [N_SRC-1:0] qual;
    logic [N_SRC-1:0] evt_pulse_q;

    // Configuration-time values: these registers are never touched by rst.
    logic             power_up_q = 1'b1;
    logic [N_SRC-1:0] cause_q    = '0;
    logic [CNT_W-1:0] evt_cnt_q  = '0;
    logic [SRC_W-1:0] last_src_q = '0;

    logic [N_SRC-1:0] cause_d;
    logic [CNT_W-1:0] evt_cnt_d;
    logic [SRC_W-1:0] last_src_d;
    logic [4:0]       pop;

    // Per-source qualification FSMs. qual[i] marks the edge that enters HELD.
    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            state_d[i] = state_q[i];
            wcnt_d[i]  = wcnt_q[i];
            qual[i]    = 1'b0;
            case (state_q[i])
                StIdle: begin
                    if (src_req[i]) begin
                        wcnt_d[i] = 8'd1;
                        if (MIN_WIDTH == 1) begin
                            state_d[i] = StHeld;
                            qual[i]    = 1'b1;
                        end else begin
                            state_d[i] = StQual;
                        end
                    end
                end
                StQual: begin
                    if (!src_req[i]) begin
                        // Too short: drop without recording anything.
                        state_d[i] = StIdle;
                        wcnt_d[i]  = 8'd0;
                    end else begin
                        wcnt_d[i] = wcnt_q[i] + 8'd1;
                        if ((9'(wcnt_q[i]) + 9'd1) >= MinW) begin
                            state_d[i] = StHeld;
                            qual[i]    = 1'b1;
                        end
                    end
                end
                StHeld: begin
                    if (!src_req[i]) begin
                        state_d[i] = StIdle;
                        wcnt_d[i]  = 8'd0;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    wcnt_d[i]  = 8'd0;
                end
            endcase
            if (rst) begin
                state_d[i] = StIdle;
                wcnt_d[i]  = 8'd0;
                qual[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                state_q[i] <= StIdle;
                wcnt_q[i]  <= 8'd0;
            end
            evt_pulse_q <= '0;
            power_up_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                state_q[i] <= state_d[i];
                wcnt_q[i]  <= wcnt_d[i];
            end
            evt_pulse_q <= qual;
        end
    end

    // Number of sources qualifying in this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            pop = pop + 5'(qual[i]);
        end
    end

`ifdef RESET_MONITOR_SAT_EN
    logic [CNT_W+4:0] sum;
    assign sum       = (CNT_W+5)'(evt_cnt_q) + (CNT_W+5)'(pop);
    assign evt_cnt_d = (|sum[CNT_W+4:CNT_W]) ? '1 : sum[CNT_W-1:0];
`else
    assign evt_cnt_d = evt_cnt_q + CNT_W'(pop);
`endif

    // Scan from high to low so the lowest qualifying index wins.
    always_comb begin
        last_src_d = last_src_q;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (qual[i]) begin
                last_src_d = SRC_W'(i);
            end
        end
    end

    // If a source qualifies in the same cycle as its clear, the new event wins.
    always_comb begin
        cause_d = cause_q;
        if (clr) begin
            cause_d = cause_d & ~clr_mask;
        end
        cause_d = cause_d | qual;
    end

    always_ff @(posedge clk) begin
        cause_q    <= cause_d;
        evt_cnt_q  <= evt_cnt_d;
        last_src_q <= last_src_d;
    end

    assign power_up  = power_up_q;
    assign cause     = cause_q;
    assign evt_pulse = evt_pulse_q;
    assign evt_cnt   = evt_cnt_q;
    assign last_src  = last_src_q;

endmodule

// File: doc/reset_monitor.md
RESET_MONITOR -- requirements
Module: reset_monitor

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of monitored reset/event sources (1..16).
REQ-002 SHALL have parameter MIN_WIDTH, default 3: consecutive high cycles a source needs to qualify (1..255).
REQ-003 SHALL have parameter CNT_W, default 8: width of the qualified-event counter (2..32).
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port src_req, input, N_SRC: raw event requests, already synchronous to clk.
REQ-007 SHALL have port clr, input, 1: one-cycle request to clear the sticky cause flags selected by clr_mask.
REQ-008 SHALL have port clr_mask, input, N_SRC: per-source select for clr.
REQ-009 SHALL have port power_up, output, 1: high from configuration until the first cycle rst is sampled high.
REQ-010 SHALL have port cause, output, N_SRC: sticky per-source qualified-event flags.
REQ-011 SHALL have port evt_pulse, output, N_SRC: one-cycle pulse per source on qualification.
REQ-012 SHALL have port evt_cnt, output, CNT_W: total count of qualified events.
REQ-013 SHALL have port last_src, output, clog2(N_SRC) (minimum 1): index of the most recently qualified source.

Function
REQ-014 Each source SHALL run its own FSM with states IDLE, QUAL and HELD.
REQ-015 From IDLE, src_req=1 SHALL go to QUAL and load the width counter with 1; src_req=0 SHALL stay in IDLE.
REQ-016 In QUAL, src_req=0 SHALL return to IDLE with no event (glitch rejected); src_req=1 SHALL increment the width counter.
REQ-017 When the width counter reaches MIN_WIDTH, the FSM SHALL go to HELD; with MIN_WIDTH=1 it SHALL go IDLE->HELD directly.
REQ-018 On the IDLE/QUAL->HELD transition edge, evt_pulse[i] SHALL be high for exactly the following cycle and cause[i] SHALL be set.
REQ-019 In HELD, no retrigger SHALL occur; src_req=0 SHALL return to IDLE.
REQ-020 Event latency SHALL be MIN_WIDTH cycles from the first high sample of src_req to evt_pulse being asserted.
REQ-021 evt_cnt SHALL add the number of sources qualifying in the same cycle (popcount), with carry handled at CNT_W bits.
REQ-022 last_src SHALL take the lowest index among the sources qualifying in a cycle, and SHALL hold its value otherwise.
REQ-023 clr SHALL clear cause[i] wherever clr_mask[i]=1; a qualification of source i in the same cycle SHALL win, leaving cause[i]=1.
REQ-024 clr SHALL NOT affect evt_cnt, last_src or the FSMs.

Reset
REQ-025 rst=1 SHALL force every FSM to IDLE, zero all width counters, and drive evt_pulse to 0 on the next cycle.
REQ-026 rst=1 SHALL clear power_up permanently; power_up SHALL never be reasserted without reconfiguration.
REQ-027 cause, evt_cnt and last_src SHALL be preserved across rst, so that reset causes survive a reset.
REQ-028 cause, evt_cnt and last_src SHALL initialise to 0 only at configuration; power_up SHALL initialise to 1.
REQ-029 While rst=1, no qualification SHALL be recorded, and clr SHALL still be honoured.
REQ-030 A source held high through a rst release SHALL restart in IDLE and requalify, taking MIN_WIDTH cycles after rst falls.

Configuration
REQ-031 With macro RESET_MONITOR_SAT_EN defined, evt_cnt SHALL saturate at all-ones and never wrap.
REQ-032 Without RESET_MONITOR_SAT_EN, evt_cnt SHALL wrap modulo 2^CNT_W.

Verification
REQ-033 MIN_WIDTH=3; src_req[1] high for 2 cycles then low -> no evt_pulse, cause=0, evt_cnt=0.
REQ-034 src_req[2] held high for 10 cycles -> single evt_pulse[2] in cycle 3, cause[2]=1, evt_cnt=1, last_src=2, no retrigger.
REQ-035 src_req[0] and src_req[3] rise in the same cycle -> both pulse together, evt_cnt +2, last_src=0.
REQ-036 cause=4'b0110, assert rst, then clr with clr_mask=4'b0010 -> power_up 1->0, cause=4'b0100, evt_cnt unchanged.
REQ-037 CNT_W=2, 5 events -> evt_cnt=3 with RESET_MONITOR_SAT_EN defined, evt_cnt=1 without it.
REQ-038 clr with clr_mask[1]=1 in the same cycle source 1 qualifies -> cause[1]=1; rst asserted mid-QUAL -> FSM returns to IDLE with no event.
